bit_serial_subtractor: RTL and testbench

Multi-cycle, LSB-first bit-serial two's-complement subtractor computing `diff = a - b` with one full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart of the ripple full-adder datapath. It sits in the lab ALU as the subtract path, where area matters more than latency. Operands are captured on a start handshake and processed one bit per clock. A one-cycle `done` pulse accompanies a registered result that is held stable.

---
 rtl/bit_serial_subtractor.sv | 128 ++++++++++++
 tb/tb_bit_serial_subtractor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial two's-complement subtractor (diff = a - b)
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic             last;

    // Single full-subtractor cell fed from the LSBs of the operand shifters
    assign a0      = sa[0];
    assign b0      = sb[0];
    assign d       = a0 ^ b0 ^ br;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign r_next  = {d, r[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            r          <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                        r     <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    r   <= r_next;
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    // Result registers only move on the edge that enters DONE
                    if (last) begin
                        diff       <= r_next;
                        borrow_out <= br_next;
                        overflow   <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - self-checking bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a_in),
        .b          (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operand values
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int          sx;
        int          sy;
        int          sdiff;
        logic [W-1:0] dd;
        logic        bo;
        logic        ov;
        sx    = (x >= 128) ? int'(x) - 256 : int'(x);
        sy    = (y >= 128) ? int'(y) - 256 : int'(y);
        sdiff = sx - sy;
        dd    = W'(int'(x) - int'(y));
        bo    = (int'(x) < int'(y));
        ov    = (sdiff > 127) || (sdiff < -128);
        return {dd, bo, ov};
    endfunction

    // Issue one operation and wait (bounded) for done; lat = -1 on timeout
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] d, output logic bo, output logic ov,
                          output int lat);
        @(negedge clk);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        lat   = -1;
        d     = 'x;
        bo    = 1'bx;
        ov    = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            if (done) begin
                lat = n;
                d   = diff;
                bo  = borrow_out;
                ov  = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_released: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
    endtask

    task automatic test_basic_timing;
        int done_at = -1;
        int done_cnt = 0;
        @(negedge clk);
        a_in  = 8'd100;
        b_in  = 8'd58;
        start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            n_checks++;
            if (busy !== (n <= 9)) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: got %b, want %b", n, busy, (n <= 9));
            end
            if (done) begin
                done_cnt++;
                done_at = n;
                n_checks++;
                if ({diff, borrow_out, overflow} !== {8'h2A, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL basic_result: got diff=%h bo=%b ov=%b, want 2a 0 0",
                             diff, borrow_out, overflow);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 9) begin
            n_fail++;
            $display("FAIL basic_done_timing: got %0d pulses last at %0d, want 1 at 9", done_cnt, done_at);
        end
    endtask

    task automatic test_vectors;
        logic [W-1:0] va [4] = '{8'h05, 8'hAA, 8'h80, 8'h7F};
        logic [W-1:0] vb [4] = '{8'h0A, 8'hAA, 8'h01, 8'hFF};
        logic [W-1:0] vd [4] = '{8'hFB, 8'h00, 8'h7F, 8'h80};
        logic         vbo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         vov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], d, bo, ov, lat);
            n_checks++;
            if (lat != 9 || {d, bo, ov} !== {vd[i], vbo[i], vov[i]}) begin
                n_fail++;
                $display("FAIL vector[%0d]: got lat=%0d diff=%h bo=%b ov=%b, want lat=9 diff=%h bo=%b ov=%b",
                         i, lat, d, bo, ov, vd[i], vbo[i], vov[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] prev;
        logic [W-1:0] got;
        int           done_cnt = 0;
        int           done_at = -1;
        prev = diff;
        @(negedge clk);
        a_in  = 8'h10;
        b_in  = 8'h01;
        start = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                start = 1'b1;
                a_in  = 8'hFF;
                b_in  = 8'h00;
            end
            if (n >= 4) begin
                start = 1'b0;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            if (done) begin
                done_cnt++;
                done_at = n;
                got = diff;
            end else if (done_cnt == 0) begin
                n_checks++;
                if (diff !== prev) begin
                    n_fail++;
                    $display("FAIL ignore_hold[%0d]: got diff=%h, want %h", n, diff, prev);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 9 || got !== 8'h0F) begin
            n_fail++;
            $display("FAIL ignore_start: got %0d pulses at %0d diff=%h, want 1 at 9 diff=0f",
                     done_cnt, done_at, got);
        end
    endtask

    task automatic test_abort_reset;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           lat;
        int           stray = 0;
        @(negedge clk);
        a_in  = 8'h50;
        b_in  = 8'h20;
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", stray);
        end
        run_op(8'h03, 8'h01, d, bo, ov, lat);
        n_checks++;
        if (lat != 9 || {d, bo, ov} !== {8'h02, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_restart: got lat=%0d diff=%h bo=%b ov=%b, want lat=9 diff=02 0 0",
                     lat, d, bo, ov);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xa [3];
        logic [W-1:0] xb [3];
        logic [W+1:0] exp_r;
        logic [W+1:0] held;
        int           k = 0;
        int           last_at = -1;
        for (int i = 0; i < 3; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
        end
        @(negedge clk);
        a_in  = xa[0];
        b_in  = xb[0];
        start = 1'b1;
        for (int n = 1; n <= 60 && k < 3; n++) begin
            @(negedge clk);
            if (done) begin
                exp_r = model(xa[k], xb[k]);
                n_checks++;
                if ({diff, borrow_out, overflow} !== exp_r) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h, want %h", k, {diff, borrow_out, overflow}, exp_r);
                end
                if (k > 0) begin
                    n_checks++;
                    if (n - last_at != 10) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d, want 10", k, n - last_at);
                    end
                end
                held    = {diff, borrow_out, overflow};
                last_at = n;
                k++;
                if (k < 3) begin
                    a_in = xa[k];
                    b_in = xb[k];
                end else begin
                    start = 1'b0;
                end
            end else if (k > 0) begin
                n_checks++;
                if ({diff, borrow_out, overflow} !== held) begin
                    n_fail++;
                    $display("FAIL b2b_hold[%0d]: got %h, want %h", n, {diff, borrow_out, overflow}, held);
                end
            end
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, want 3", k);
        end
        for (int n = 0; n < 14; n++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic [W+1:0] exp_r;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            y = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            exp_r = model(x, y);
            run_op(x, y, d, bo, ov, lat);
            n_checks++;
            if (lat != 9 || {d, bo, ov} !== exp_r) begin
                n_fail++;
                $display("FAIL random[%0d] %h-%h: got lat=%0d %h, want lat=9 %h",
                         i, x, y, lat, {d, bo, ov}, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_vectors();
        test_ignore_start();
        test_abort_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
